// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the PONG UART transmit path.
//   c_BYTE_W   : width of one transmitted byte
//   c_MAX_REQ  : largest number of byte sources the TX arbiter supports
//   s_IDLE / s_LAUNCH / s_WAIT : one-hot TX arbiter state encodings
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned c_BYTE_W  = 8;
  localparam int unsigned c_MAX_REQ = 8;

  localparam logic [2:0] s_IDLE   = 3'b001;
  localparam logic [2:0] s_LAUNCH = 3'b010;
  localparam logic [2:0] s_WAIT   = 3'b100;

endpackage : uart_pkg

// File: rtl/uart_rr_select.sv
// -----------------------------------------------------------------------------
// uart_rr_select
// Combinational round-robin pick: the first set request found searching
// upward from the pointer position, wrapping modulo c_NUM_REQ.
//   req_i   : request vector
//   ptr_i   : search start index (must be < c_NUM_REQ)
//   grant_o : one-hot winner, zero when nothing is requesting
//   valid_o : at least one request present
// -----------------------------------------------------------------------------
module uart_rr_select #(
  parameter int c_NUM_REQ = 4,
  parameter int c_PTR_W   = $clog2(c_NUM_REQ)
) (
  input  logic [c_NUM_REQ-1:0] req_i,
  input  logic [c_PTR_W-1:0]   ptr_i,
  output logic [c_NUM_REQ-1:0] grant_o,
  output logic                 valid_o
);

  logic [c_NUM_REQ-1:0] req_rot;
  logic [c_NUM_REQ-1:0] first_rot;

  always_comb begin
    // Rotate right so the pointer position lands on bit 0, isolate the lowest
    // set bit, then rotate back left by the same amount.
    req_rot   = c_NUM_REQ'({req_i, req_i} >> ptr_i);
    first_rot = req_rot & (-req_rot);
    grant_o   = c_NUM_REQ'(({first_rot, first_rot} << ptr_i) >> c_NUM_REQ);
  end

  assign valid_o = |req_i;

endmodule : uart_rr_select

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between c_NUM_REQ byte sources. Round-robin
// grant, launch into the serializer, wait for DONE (or a timeout), then move
// the pointer past the owner.
//
// Ports:
//   i_CLK, i_RST      : clock, synchronous active-high reset
//   i_REQ, i_DATA     : per-requester request level and flattened bytes
//   i_LAST            : final byte of a burst (burst build only)
//   o_GRANT           : one-hot current owner, 0 when idle
//   o_ACK             : one-cycle pulse, owner's byte consumed
//   o_TX_START        : one-cycle launch strobe to the transmitter
//   o_TX_DATA         : byte to the transmitter, held until the next launch
//   i_TX_BUSY         : transmitter active
//   i_TX_DONE         : transmitter finished the byte (ignored outside WAIT)
//   o_TIMEOUT         : one-cycle pulse when WAIT expires without DONE
//
// Build option: define UART_ARB_BURST_EN to keep the grant on the same owner
// until it sends a byte marked i_LAST (multi-byte messages stay contiguous).
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int c_NUM_REQ        = 4,
  parameter int c_TIMEOUT_CYCLES = 8192
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [c_NUM_REQ-1:0]          i_REQ,
  input  logic [c_BYTE_W*c_NUM_REQ-1:0] i_DATA,
  input  logic [c_NUM_REQ-1:0]          i_LAST,
  output logic [c_NUM_REQ-1:0]          o_GRANT,
  output logic [c_NUM_REQ-1:0]          o_ACK,
  output logic                          o_TX_START,
  output logic [c_BYTE_W-1:0]           o_TX_DATA,
  input  logic                          i_TX_BUSY,
  input  logic                          i_TX_DONE,
  output logic                          o_TIMEOUT
);

  localparam int c_PTR_W = $clog2(c_NUM_REQ);
  localparam int c_CNT_W = $clog2(c_TIMEOUT_CYCLES);
  localparam logic [c_PTR_W-1:0] c_PTR_MAX  = c_PTR_W'(c_NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q,   state_d;
  logic [c_PTR_W-1:0]   ptr_q,     ptr_d;
  logic [c_CNT_W-1:0]   cnt_q,     cnt_d;
  logic [c_NUM_REQ-1:0] grant_q,   grant_d;
  logic [c_NUM_REQ-1:0] ack_q,     ack_d;
  logic                 start_q,   start_d;
  logic [c_BYTE_W-1:0]  data_q,    data_d;
  logic                 timeout_q, timeout_d;

  logic [c_NUM_REQ-1:0] sel_grant;
  logic                 sel_valid;
  logic [c_PTR_W-1:0]   owner_idx;
  logic [c_PTR_W-1:0]   ptr_after_owner;
  logic [c_BYTE_W-1:0]  owner_data;
  logic                 owner_req;

`ifdef UART_ARB_BURST_EN
  logic                 last_q, last_d;
  logic                 owner_last;
  assign owner_last = |(i_LAST & grant_q);
`else
  logic                 unused_last;
  assign unused_last = ^i_LAST;
`endif

  uart_rr_select #(
    .c_NUM_REQ (c_NUM_REQ),
    .c_PTR_W   (c_PTR_W)
  ) u_rr_select (
    .req_i   (i_REQ),
    .ptr_i   (ptr_q),
    .grant_o (sel_grant),
    .valid_o (sel_valid)
  );

  // Owner-side views derived from the registered one-hot grant.
  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int k = 0; k < c_NUM_REQ; k++) begin
      if (grant_q[k]) owner_idx = c_PTR_W'(k);
      owner_data = owner_data | (i_DATA[c_BYTE_W*k +: c_BYTE_W] & {c_BYTE_W{grant_q[k]}});
    end
  end

  assign owner_req       = |(i_REQ & grant_q);
  assign ptr_after_owner = (owner_idx == c_PTR_MAX) ? '0 : owner_idx + c_PTR_W'(1);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    data_d    = data_q;
    ack_d     = '0;
    start_d   = 1'b0;
    timeout_d = 1'b0;
`ifdef UART_ARB_BURST_EN
    last_d    = last_q;
`endif
    case (state_q)
      s_IDLE: begin
        if (sel_valid) begin
          grant_d = sel_grant;
          state_d = s_LAUNCH;
        end
      end
      s_LAUNCH: begin
        if (!owner_req) begin
          // Requester withdrew before launch: give up without moving the pointer.
          grant_d = '0;
          state_d = s_IDLE;
        end else if (!i_TX_BUSY) begin
          data_d  = owner_data;
          start_d = 1'b1;
          ack_d   = grant_q;
          cnt_d   = '0;
`ifdef UART_ARB_BURST_EN
          last_d  = owner_last;
`endif
          state_d = s_WAIT;
        end
      end
      s_WAIT: begin
        // DONE is checked first so a coincident expiry never raises o_TIMEOUT.
        if (i_TX_DONE) begin
`ifdef UART_ARB_BURST_EN
          if (!last_q && owner_req) begin
            state_d = s_LAUNCH;
          end else
`endif
          begin
            ptr_d   = ptr_after_owner;
            grant_d = '0;
            state_d = s_IDLE;
          end
        end else if (cnt_q == c_CNT_LAST) begin
          timeout_d = 1'b1;
          ptr_d     = ptr_after_owner;
          grant_d   = '0;
          state_d   = s_IDLE;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: non-blocking assignments for all state, so every register here
    // updates from pre-edge values regardless of statement order.
    if (i_RST) begin
      state_q   <= s_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
`ifdef UART_ARB_BURST_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
`ifdef UART_ARB_BURST_EN
      last_q    <= last_d;
`endif
    end
  end

  assign o_GRANT    = grant_q;
  assign o_ACK      = ack_q;
  assign o_TX_START = start_q;
  assign o_TX_DATA  = data_q;
  assign o_TIMEOUT  = timeout_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Drives uart_tx_arbiter with directed scenarios followed by randomized
// requesters and an emulated transmitter. A transaction-level reference model
// predicts every output each cycle; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic           done;
  logic [N-1:0]   req;
  logic [N-1:0]   last;
  logic [8*N-1:0] data;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           start;
  logic           tmo;
  logic [7:0]     txd;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .c_NUM_REQ        (N),
    .c_TIMEOUT_CYCLES (T)
  ) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_REQ      (req),
    .i_DATA     (data),
    .i_LAST     (last),
    .o_GRANT    (grant),
    .o_ACK      (ack),
    .o_TX_START (start),
    .o_TX_DATA  (txd),
    .i_TX_BUSY  (busy),
    .i_TX_DONE  (done),
    .o_TIMEOUT  (tmo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Requester sources: one pending byte each.
  bit         rq [N];
  logic [7:0] rb [N];
  bit         rl [N];
  bit         rand_last = 1'b0;
  int         refill    = 0;   // 0: drop after ACK, 1: next byte at once, 2: coin flip

  // Transmitter emulation.
  bit tx_auto  = 1'b1;
  bit tx_rand  = 1'b0;
  bit stray_en = 1'b0;
  int tx_len   = 5;
  int tx_left  = 0;

  // Reference model: who owns the transmitter, whether its byte is in flight.
  int         m_owner    = -1;
  int         m_ptr      = 0;
  int         m_age      = 0;
  bit         m_launched = 1'b0;
  bit         m_last     = 1'b0;
  logic [N-1:0] exp_grant = '0;
  logic [N-1:0] exp_ack   = '0;
  logic         exp_start = 1'b0;
  logic         exp_to    = 1'b0;
  logic [7:0]   exp_data  = '0;

  int starts[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int pick_len();
    int r = $urandom_range(0, 9);
    if (r == 0) return T;          // DONE lands exactly on the expiry cycle
    if (r == 1) return T + 10;     // too slow: arbiter gives up first
    return $urandom_range(1, 12);
  endfunction

  task automatic new_byte(input int k);
    rq[k] = 1'b1;
    rb[k] = 8'($urandom);
    rl[k] = rand_last ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Predict the outputs that follow from the inputs now being driven.
  task automatic model_step();
    exp_start = 1'b0;
    exp_ack   = '0;
    exp_to    = 1'b0;
    if (rst) begin
      m_owner = -1; m_launched = 1'b0; m_ptr = 0; m_age = 0; m_last = 1'b0;
      exp_data = '0;
    end else if (m_owner < 0) begin
      m_owner = rr_pick(req, m_ptr);
    end else if (!m_launched) begin
      if (!req[m_owner]) begin
        m_owner = -1;
      end else if (!busy) begin
        exp_data   = data[8*m_owner +: 8];
        m_last     = last[m_owner];
        exp_start  = 1'b1;
        exp_ack[m_owner] = 1'b1;
        m_launched = 1'b1;
        m_age      = 0;
      end
    end else if (done) begin
`ifdef UART_ARB_BURST_EN
      if (!m_last && req[m_owner]) m_launched = 1'b0;
      else
`endif
      begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_launched = 1'b0;
      end
    end else if (m_age == T - 1) begin
      exp_to = 1'b1;
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_launched = 1'b0;
    end else begin
      m_age++;
    end
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
  endtask

  // One clock: drive inputs, predict, clock, compare, react.
  task automatic advance();
    int who;
    if (tx_auto) begin
      if (tx_left > 0) begin
        busy = 1'b1; done = (tx_left == 1); tx_left--;
      end else begin
        busy = 1'b0; done = stray_en && ($urandom_range(0, 7) == 0);
      end
    end
    for (int k = 0; k < N; k++) begin
      req[k] = rq[k]; data[8*k +: 8] = rb[k]; last[k] = rl[k];
    end
    model_step();
    @(posedge clk); #1;
    check("grant",    32'(grant), 32'(exp_grant));
    check("ack",      32'(ack),   32'(exp_ack));
    check("start",    32'(start), 32'(exp_start));
    check("timeout",  32'(tmo),   32'(exp_to));
    check("tx_data",  32'(txd),   32'(exp_data));
    if (start) begin
      who = 99;
      for (int k = 0; k < N; k++) if (ack[k]) who = k;
      starts.push_back(who);
      if (tx_auto) tx_left = tx_rand ? pick_len() : tx_len;
    end
    for (int k = 0; k < N; k++) begin
      if (exp_ack[k]) begin
        if (refill == 1 || (refill == 2 && $urandom_range(0, 1) == 1)) new_byte(k);
        else rq[k] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) advance();
  endtask

  task automatic wait_start(input int maxc);
    int n = 0;
    while (!start && n < maxc) begin
      advance();
      n++;
    end
    check("start_seen", 32'(start), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int cnt;
  int lat;
  logic [N-1:0] g_after;

  initial begin
    // NOTE: bench drives inputs with blocking assignments, one edge ahead of use.
    rst = 1'b1; busy = 1'b0; done = 1'b0; req = '0; last = '0; data = '0;
    for (int k = 0; k < N; k++) begin rq[k] = 1'b0; rb[k] = '0; rl[k] = 1'b1; end

    // Reset state.
    advance();
    advance();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_data",  32'(txd),   32'd0);
    rst = 1'b0;
    advance();

    // Single requester 2, byte 0xA5, transmitter idle.
    new_byte(2); rb[2] = 8'hA5;
    advance();
    check("k2_grant_t1", 32'(grant), 32'h4);
    check("k2_start_t1", 32'(start), 32'd0);
    advance();
    check("k2_start_t2", 32'(start), 32'd1);
    check("k2_ack_t2",   32'(ack),   32'h4);
    check("k2_data_t2",  32'(txd),   32'hA5);
    run(5);
    check("k2_done_clear", 32'(grant), 32'd0);
    new_byte(0); new_byte(3);
    advance();
    check("ptr_after_k2", 32'(grant), 32'h8);
    run(40);

    // All four requesting continuously from reset.
    do_reset();
    starts.delete();
    refill = 1;
    for (int k = 0; k < N; k++) new_byte(k);
    run(50);
    refill = 0;
    check("order_count", 32'(starts.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("order%0d", i), 32'((i < starts.size()) ? starts[i] : 99), 32'(exp_order[i]));
    run(50);

    // Transmitter busy for 20 cycles while in LAUNCH.
    tx_auto = 1'b0; busy = 1'b0; done = 1'b0;
    do_reset();
    busy = 1'b1;
    new_byte(1);
    advance();
    check("busy_grant", 32'(grant), 32'h2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      advance();
      if (start) cnt++;
    end
    check("busy_no_start", 32'(cnt), 32'd0);
    busy = 1'b0;
    advance();
    check("busy_release_start", 32'(start), 32'd1);
    check("busy_release_ack",   32'(ack),   32'h2);
    run(3);
    done = 1'b1;
    advance();
    done = 1'b0;
    run(2);

    // Requester 1 withdraws in LAUNCH; pointer must stay at 0.
    do_reset();
    busy = 1'b1;
    new_byte(1);
    advance();
    advance();
    rq[1] = 1'b0;
    advance();
    check("drop_grant", 32'(grant), 32'd0);
    check("drop_ack",   32'(ack),   32'd0);
    busy = 1'b0;
    tx_auto = 1'b1;
    new_byte(1); new_byte(2);
    advance();
    check("drop_ptr_hold", 32'(grant), 32'h2);
    run(40);

    // No DONE in time: timeout 16 cycles after START, next requester granted.
    tx_len = T + 20;
    new_byte(2);
    wait_start(10);
    new_byte(3);
    lat = -1;
    g_after = '0;
    for (int i = 1; i <= 40; i++) begin
      advance();
      if (tmo && lat < 0) lat = i;
      if (lat > 0 && i == lat + 1) g_after = grant;
    end
    check("timeout_latency", 32'(lat),     32'd16);
    check("timeout_next",    32'(g_after), 32'h8);
    run(40);

    // DONE on the expiry cycle: no timeout pulse.
    tx_len = T;
    new_byte(0);
    wait_start(10);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      advance();
      if (tmo) cnt++;
    end
    check("coincident_no_timeout", 32'(cnt), 32'd0);

    // Reset mid-WAIT; the transmitter's later DONE must be ignored.
    tx_len = 10;
    new_byte(0);
    wait_start(10);
    run(3);
    rst = 1'b1;
    advance();
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_ack",   32'(ack),   32'd0);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_data",  32'(txd),   32'd0);
    check("midrst_tmo",   32'(tmo),   32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      advance();
      if (ack != '0 || grant != '0) cnt++;
    end
    check("stray_done_ignored", 32'(cnt), 32'd0);

    // Randomized traffic against the reference model.
    rand_last = 1'b1; tx_rand = 1'b1; stray_en = 1'b1; refill = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!rq[k] && $urandom_range(0, 3) == 0) new_byte(k);
        else if (rq[k] && $urandom_range(0, 63) == 0) rq[k] = 1'b0;
      end
      rst = ($urandom_range(0, 399) == 0);
      advance();
    end
    rst = 1'b0; refill = 0; stray_en = 1'b0;
    for (int k = 0; k < N; k++) rq[k] = 1'b0;
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
